// File: rtl/atm_functions_if.sv
// rtl/atm_functions_if.sv - menu/account request and status bundle for the ATM transaction engine
interface atm_functions_if;
  logic [2:0]  operation;
  logic [3:0]  acc_num;
  logic [15:0] pin;
  logic [15:0] new_pin;
  logic [15:0] amount;
  logic [3:0]  acc_index;
  logic        acc_found;
  logic        acc_auth;
  logic [15:0] balance;
  logic [2:0]  state;
  logic        error;

  modport master (
    output operation, acc_num, pin, new_pin, amount,
    input  acc_index, acc_found, acc_auth, balance, state, error
  );

  modport slave (
    input  operation, acc_num, pin, new_pin, amount,
    output acc_index, acc_found, acc_auth, balance, state, error
  );
endinterface

// File: rtl/atm_functions.sv
// rtl/atm_functions.sv - account store, PIN authenticator and session state machine
module atm_functions (
  input  logic             clk,
  input  logic             rst_n,
  atm_functions_if.slave   bus
);
  typedef enum logic [2:0] {
    ST_WAITING    = 3'd0,
    ST_BALANCE    = 3'd1,
    ST_WITHDRAW   = 3'd2,
    ST_DEPOSIT    = 3'd3,
    ST_CHANGE_PIN = 3'd4,
    ST_MENU       = 3'd6
  } state_t;

  localparam int          NUM_ACC  = 10;
  localparam logic [15:0] INIT_BAL = 16'd500;
  localparam logic [15:0] PIN_BASE = 16'd1000;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] balance_q, balance_d;
  logic        error_q, error_d;
  logic [15:0] bal_q [NUM_ACC];
  logic [15:0] pin_q [NUM_ACC];

  logic        bal_we;
  logic [15:0] bal_wdata;
  logic        pin_we;
  logic [15:0] cur_bal;
  logic [16:0] sum;

  // Authenticator: pure function of the presented card number and PIN
  always_comb begin
    bus.acc_found = (bus.acc_num <= 4'd9);
    bus.acc_index = bus.acc_found ? bus.acc_num : 4'd0;
    bus.acc_auth  = bus.acc_found && (bus.pin == pin_q[bus.acc_index]);
  end

  assign cur_bal = bal_q[idx_q];
  assign sum     = {1'b0, cur_bal} + {1'b0, bus.amount};

  // Next state; each action is committed on the edge that enters its action state
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    balance_d = balance_q;
    error_d   = error_q;
    bal_we    = 1'b0;
    bal_wdata = cur_bal;
    pin_we    = 1'b0;
    case (state_q)
      ST_WAITING: begin
        if (bus.acc_auth) begin
          state_d = ST_MENU;
          idx_d   = bus.acc_index;
        end
      end
      ST_MENU: begin
        case (bus.operation)
          3'd1: begin
            state_d   = ST_BALANCE;
            balance_d = cur_bal;
            error_d   = 1'b0;
          end
          3'd2: begin
            state_d = ST_WITHDRAW;
            if (bus.amount <= cur_bal) begin
              bal_we    = 1'b1;
              bal_wdata = cur_bal - bus.amount;
              error_d   = 1'b0;
            end else begin
              error_d   = 1'b1;
            end
            balance_d = bal_wdata;
          end
          3'd3: begin
            state_d = ST_DEPOSIT;
            if (!sum[16]) begin
              bal_we    = 1'b1;
              bal_wdata = sum[15:0];
              error_d   = 1'b0;
            end else begin
              error_d   = 1'b1;
            end
            balance_d = bal_wdata;
          end
          3'd4: begin
            state_d   = ST_CHANGE_PIN;
            pin_we    = 1'b1;
            balance_d = cur_bal;
            error_d   = 1'b0;
          end
          3'd5: begin
            state_d   = ST_WAITING;
            idx_d     = 4'd0;
            balance_d = 16'd0;
            error_d   = 1'b0;
          end
          default: state_d = ST_MENU;
        endcase
      end
      ST_BALANCE, ST_WITHDRAW, ST_DEPOSIT, ST_CHANGE_PIN: state_d = ST_MENU;
      default: state_d = ST_WAITING;
    endcase
  end

  // Session registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_WAITING;
      idx_q     <= 4'd0;
      balance_q <= 16'd0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      balance_q <= balance_d;
      error_q   <= error_d;
    end
  end

  // Account databases; reset restores factory balances and PINs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        bal_q[i] <= INIT_BAL;
        pin_q[i] <= PIN_BASE + 16'(i);
      end
    end else begin
      if (bal_we) bal_q[idx_q] <= bal_wdata;
      if (pin_we) pin_q[idx_q] <= bus.new_pin;
    end
  end

  assign bus.balance = balance_q;
  assign bus.error   = error_q;
  assign bus.state   = state_q;
endmodule

// File: tb/tb_atm_functions.sv
// tb/tb_atm_functions.sv - directed self-checking bench for atm_functions
module tb_atm_functions;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  atm_functions_if bus ();

  atm_functions dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.operation = 3'd0;
    bus.acc_num   = 4'd0;
    bus.pin       = 16'd0;
    bus.new_pin   = 16'd0;
    bus.amount    = 16'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_balance", 32'(bus.balance), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    rst_n = 1'b1;

    // login account 3, balance inquiry
    bus.acc_num = 4'd3; bus.pin = 16'd1003; #1;
    chk("auth3_found", 32'(bus.acc_found), 32'd1);
    chk("auth3_auth", 32'(bus.acc_auth), 32'd1);
    chk("auth3_index", 32'(bus.acc_index), 32'd3);
    step();
    chk("login3_state", 32'(bus.state), 32'd6);
    chk("login3_balance", 32'(bus.balance), 32'd0);
    bus.operation = 3'd1; step();
    chk("bal3_state", 32'(bus.state), 32'd1);
    chk("bal3_balance", 32'(bus.balance), 32'd500);
    chk("bal3_error", 32'(bus.error), 32'd0);
    bus.operation = 3'd0; step();
    chk("bal3_menu", 32'(bus.state), 32'd6);
    chk("menu_hold_balance", 32'(bus.balance), 32'd500);

    // withdrawals: ok, overdraw, exact full balance
    bus.amount = 16'd200; bus.operation = 3'd2; step();
    chk("wd200_state", 32'(bus.state), 32'd2);
    chk("wd200_balance", 32'(bus.balance), 32'd300);
    chk("wd200_error", 32'(bus.error), 32'd0);
    bus.operation = 3'd0; step();
    bus.amount = 16'd400; bus.operation = 3'd2; step();
    chk("wd400_balance", 32'(bus.balance), 32'd300);
    chk("wd400_error", 32'(bus.error), 32'd1);
    bus.operation = 3'd0; step();
    chk("menu_hold_error", 32'(bus.error), 32'd1);
    bus.amount = 16'd300; bus.operation = 3'd2; step();
    chk("wd300_balance", 32'(bus.balance), 32'd0);
    chk("wd300_error", 32'(bus.error), 32'd0);
    bus.operation = 3'd0; step();
    bus.operation = 3'd5; step();
    chk("exit3_state", 32'(bus.state), 32'd0);
    chk("exit3_balance", 32'(bus.balance), 32'd0);
    bus.operation = 3'd0;

    // wrong PIN and nonexistent account
    bus.pin = 16'd1004; #1;
    chk("bad_pin_found", 32'(bus.acc_found), 32'd1);
    chk("bad_pin_auth", 32'(bus.acc_auth), 32'd0);
    step();
    chk("bad_pin_state", 32'(bus.state), 32'd0);
    bus.acc_num = 4'd12; #1;
    chk("acc12_found", 32'(bus.acc_found), 32'd0);
    chk("acc12_index", 32'(bus.acc_index), 32'd0);
    chk("acc12_auth", 32'(bus.acc_auth), 32'd0);

    // deposit overflow then exact fill on account 5
    bus.acc_num = 4'd5; bus.pin = 16'd1005; step();
    chk("login5_state", 32'(bus.state), 32'd6);
    bus.amount = 16'd65100; bus.operation = 3'd3; step();
    chk("dep_ovf_state", 32'(bus.state), 32'd3);
    chk("dep_ovf_error", 32'(bus.error), 32'd1);
    chk("dep_ovf_balance", 32'(bus.balance), 32'd500);
    bus.operation = 3'd0; step();
    bus.amount = 16'd65035; bus.operation = 3'd3; step();
    chk("dep_max_balance", 32'(bus.balance), 32'd65535);
    chk("dep_max_error", 32'(bus.error), 32'd0);
    bus.operation = 3'd0; step();
    bus.amount = 16'd0; bus.operation = 3'd2; step();
    chk("wd0_balance", 32'(bus.balance), 32'd65535);
    bus.operation = 3'd0; step();
    bus.operation = 3'd5; step();
    bus.operation = 3'd0;

    // PIN change on account 2
    bus.acc_num = 4'd2; bus.pin = 16'd1002; step();
    chk("login2_state", 32'(bus.state), 32'd6);
    bus.new_pin = 16'd4321; bus.operation = 3'd4; step();
    chk("chpin_state", 32'(bus.state), 32'd4);
    chk("chpin_error", 32'(bus.error), 32'd0);
    bus.operation = 3'd0; step();
    bus.operation = 3'd5; step();
    bus.operation = 3'd0;
    #1;
    chk("old_pin_auth", 32'(bus.acc_auth), 32'd0);
    step();
    chk("old_pin_state", 32'(bus.state), 32'd0);
    bus.pin = 16'd4321; #1;
    chk("new_pin_auth", 32'(bus.acc_auth), 32'd1);
    step();
    chk("new_pin_state", 32'(bus.state), 32'd6);
    bus.operation = 3'd1; step();
    chk("new_pin_balance", 32'(bus.balance), 32'd500);
    bus.operation = 3'd0; step();
    bus.operation = 3'd5; step();
    bus.operation = 3'd0;

    // reset in the middle of a withdrawal
    bus.acc_num = 4'd3; bus.pin = 16'd1003; step();
    bus.amount = 16'd0; bus.operation = 3'd2; step();
    chk("pre_rst_state", 32'(bus.state), 32'd2);
    rst_n = 1'b0; #1;
    chk("mid_rst_state", 32'(bus.state), 32'd0);
    chk("mid_rst_balance", 32'(bus.balance), 32'd0);
    chk("mid_rst_error", 32'(bus.error), 32'd0);
    bus.operation = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.acc_num = 4'd2; bus.pin = 16'd4321; #1;
    chk("rst_pin2_auth", 32'(bus.acc_auth), 32'd0);
    bus.acc_num = 4'd3; bus.pin = 16'd1003; #1;
    chk("rst_pin3_auth", 32'(bus.acc_auth), 32'd1);
    step();
    chk("relogin3_state", 32'(bus.state), 32'd6);
    bus.operation = 3'd1; step();
    chk("rst_bal3", 32'(bus.balance), 32'd500);
    bus.operation = 3'd0; step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/atm_functions.md
# atm_functions

Account-database and transaction engine for the ATM design. It authenticates an account number and PIN against internal tables, then runs a session state machine. The session covers balance inquiry, withdrawal, deposit and PIN change on a 10-entry account store. It sits directly under the ATM top level, and its state and balance outputs drive the display and menu logic.

## Interface
No parameters. Fixed constants: 10 accounts; initial balance 500; default PIN of account i is 1000+i (decimal).
- clk  in  1  system clock; all state updates occur on the rising edge
- rst_n  in  1  asynchronous active-low reset
- operation  in  3  menu selection: 1 BALANCE, 2 WITHDRAW, 3 DEPOSIT, 4 CHANGE_PIN, 5 EXIT
- acc_num  in  4  account number presented by the card
- pin  in  16  entered PIN
- new_pin  in  16  replacement PIN, used only by CHANGE_PIN
- amount  in  16  unsigned transaction amount
- acc_index  out  4  index of the matched account (combinational)
- acc_found  out  1  acc_num names an existing account (combinational)
- acc_auth  out  1  acc_found and pin equals the stored PIN (combinational)
- balance  out  16  balance of the session account (registered)
- state  out  3  current state: 0 WAITING, 1 BALANCE, 2 WITHDRAW, 3 DEPOSIT, 4 CHANGE_PIN, 6 MENU
- error  out  1  last transaction rejected (registered)

## Operation
- Authenticator (combinational):
  - acc_found=1 iff acc_num ≤ 9.
  - acc_index=acc_num when found, else 0.
  - acc_auth=acc_found && (pin == pin_db[acc_num]).
- Session account index: registered on the WAITING→MENU transition and held until the machine returns to WAITING. Inputs acc_num and pin are ignored while a session is open.
- State transitions (one per clk):
  - WAITING: acc_auth=1 → MENU; otherwise stay.
  - MENU: operation 1–4 → the same-numbered state; 5 → WAITING; 0, 6 or 7 → stay in MENU.
  - BALANCE, WITHDRAW, DEPOSIT, CHANGE_PIN: perform the action in that cycle, then → MENU.
- Actions:
  - BALANCE: balance ← bal_db[idx]; error ← 0.
  - WITHDRAW:
    - amount ≤ bal_db[idx]: bal_db[idx] ← bal_db[idx] − amount; error ← 0.
    - otherwise: no change; error ← 1.
  - DEPOSIT (17-bit sum):
    - sum ≤ 65535: bal_db[idx] ← sum; error ← 0.
    - otherwise: no change; error ← 1.
  - CHANGE_PIN: pin_db[idx] ← new_pin; error ← 0.
  - In every action state, balance shows the post-action value of bal_db[idx].
- An amount of 0 is legal and leaves the balance unchanged.
- A withdrawal of exactly the full balance is legal and leaves 0.
- Leaving to WAITING clears balance to 0 and error to 0.
- balance and error hold their values in MENU.
- The databases persist across sessions; only reset reinitialises them.

## Timing
- Reset asserted, at any time and including mid-transaction:
  - state=WAITING, balance=0, error=0.
  - Every bal_db entry=500; every pin_db entry=1000+i.
  - The session index clears to 0.
  - Any in-flight action is discarded.
- Latencies:
  - Authenticator outputs follow the inputs in the same cycle, with no clock dependence.
  - Login takes 1 edge (WAITING→MENU).
  - An operation needs 1 edge to enter its action state. Its effect is visible on balance and error after that edge. The machine returns to MENU on the next edge, so each transaction takes 2 cycles.
- One action is performed per visit to an action state. Holding operation constant in MENU re-dispatches the same operation every 2 cycles.
- No handshake. Inputs are sampled on the rising edge and must be stable around it.

## Test plan
- Reset, then acc_num=3, pin=1003 → acc_found=1 and acc_auth=1 immediately; state=MENU after 1 edge; operation=1 → balance=500, error=0.
- Wrong PIN: acc_num=3, pin=1004 → acc_found=1, acc_auth=0, state stays WAITING. Then acc_num=12 → acc_found=0.
- Withdraw 200 on account 3 → balance=300; then withdraw 400 → error=1, balance=300; then withdraw 300 → balance=0, error=0.
- Deposit 65100 on account 5 (balance 500) → error=1, balance=500. Then deposit 65035 → balance=65535.
- CHANGE_PIN on account 2 with new_pin=4321, EXIT, then log in with pin=1002 → rejected; log in with pin=4321 → MENU, balance=500.
- Assert rst_n low while in the WITHDRAW state → state=WAITING, balance=0. After release, account 3 reads 500 and PIN 1003 is valid again.
